// File: rtl/arith_seq_ctrl_pkg.sv
// ALUOperations: shared operation encoding, flag layout and sequencer types.
// Used by the single-cycle arithmetic unit and by the multi-cycle sequencer
// (arith_seq_ctrl) so that both produce results and flags in the same format.
package ALUOperations;

    typedef enum logic [4:0] {
        ALU_ADD    = 5'd0,
        ALU_SUB    = 5'd1,
        ALU_AND    = 5'd2,
        ALU_OR     = 5'd3,
        ALU_XOR    = 5'd4,
        ALU_SLL    = 5'd5,
        ALU_SRL    = 5'd6,
        ALU_SRA    = 5'd7,
        ALU_SLT    = 5'd8,
        ALU_SLTU   = 5'd9,
        ALU_MUL    = 5'd16,
        ALU_MULH   = 5'd17,
        ALU_MULHSU = 5'd18,
        ALU_MULHU  = 5'd19,
        ALU_DIV    = 5'd20,
        ALU_DIVU   = 5'd21,
        ALU_REM    = 5'd22,
        ALU_REMU   = 5'd23
    } alu_op_t;

    localparam int ARITH_SEQ_ITERS = 32;
    localparam int ARITH_SEQ_CNT_W = $clog2(ARITH_SEQ_ITERS);

    // Flag vector bit positions.
    localparam int FLAG_ZERO        = 0;
    localparam int FLAG_SIGN        = 1;
    localparam int FLAG_ODD_PARITY  = 2;
    localparam int FLAG_EVEN_PARITY = 3;
    localparam int FLAG_OVERFLOW    = 4;
    localparam int FLAG_CARRY       = 5;
    localparam int FLAG_DIV0        = 6;
    localparam int FLAG_W           = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FIXUP = 2'd2,
        DONE  = 2'd3
    } seq_state_t;

    typedef enum logic {
        STEP_MUL = 1'b0,
        STEP_DIV = 1'b1
    } step_mode_t;

    function automatic logic isMulOp(input alu_op_t op);
        return op inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU};
    endfunction

    function automatic logic isDivOp(input alu_op_t op);
        return op inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
    endfunction

    function automatic logic opSignedA(input alu_op_t op);
        return op inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_DIV, ALU_REM};
    endfunction

    function automatic logic opSignedB(input alu_op_t op);
        return op inside {ALU_MUL, ALU_MULH, ALU_DIV, ALU_REM};
    endfunction

    // Flags derived from a final result; carry is never produced by the long ops.
    function automatic logic [FLAG_W-1:0] makeFlags(input logic [31:0] res,
                                                    input logic div0,
                                                    input logic ovf);
        logic [FLAG_W-1:0] f;
        f                   = '0;
        f[FLAG_ZERO]        = (res == 32'd0);
        f[FLAG_SIGN]        = res[31];
        f[FLAG_ODD_PARITY]  = ^res;
        f[FLAG_EVEN_PARITY] = ~(^res);
        f[FLAG_OVERFLOW]    = ovf;
        f[FLAG_CARRY]       = 1'b0;
        f[FLAG_DIV0]        = div0;
        return f;
    endfunction

endpackage

// File: rtl/arith_seq_ctrl_if.sv
// Request/response bundle between the issue stage and the long-op sequencer.
//   in_valid/in_ready/in_op/in_a/in_b : request handshake and operands
//   flush                             : abort any op or held result
//   out_valid/out_ready               : result handshake
//   out_result/out_flags              : result word and flag vector
// master = requester side, slave = sequencer side.
interface arith_seq_ctrl_if;
    import ALUOperations::*;

    logic                in_valid;
    logic                in_ready;
    alu_op_t             in_op;
    logic [31:0]         in_a;
    logic [31:0]         in_b;
    logic                flush;
    logic                out_valid;
    logic                out_ready;
    logic [31:0]         out_result;
    logic [FLAG_W-1:0]   out_flags;

    modport master (
        output in_valid, in_op, in_a, in_b, flush, out_ready,
        input  in_ready, out_valid, out_result, out_flags
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, flush, out_ready,
        output in_ready, out_valid, out_result, out_flags
    );
endinterface

// File: rtl/arith_seq_ctrl_step.sv
// arith_seq_step: one radix-2 iteration, purely combinational.
//   accIn/accOut : partial product high half / partial remainder (XLEN+1 bits)
//   mqIn/mqOut   : multiplier being shifted out / dividend shifting into quotient
//   operand      : multiplicand or divisor magnitude
//   mode         : STEP_MUL (shift-add) or STEP_DIV (restoring shift-subtract)
module arith_seq_step
    import ALUOperations::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN:0]   accIn,
    input  logic [XLEN-1:0] mqIn,
    input  logic [XLEN-1:0] operand,
    input  step_mode_t      mode,
    output logic [XLEN:0]   accOut,
    output logic [XLEN-1:0] mqOut
);

    logic [XLEN:0] sum;
    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    always_comb begin
        accOut  = accIn;
        mqOut   = mqIn;
        sum     = '0;
        shifted = '0;
        diff    = '0;
        if (mode == STEP_DIV) begin
            // Remainder stays below the divisor, so the shifted value fits XLEN+1 bits.
            shifted = {accIn[XLEN-1:0], mqIn[XLEN-1]};
            diff    = shifted - {1'b0, operand};
            if (shifted >= {1'b0, operand}) begin
                accOut = diff;
                mqOut  = {mqIn[XLEN-2:0], 1'b1};
            end else begin
                accOut = shifted;
                mqOut  = {mqIn[XLEN-2:0], 1'b0};
            end
        end else begin
            // The product's low bits shift down into mq as the multiplier bits retire.
            sum    = accIn + (mqIn[0] ? {1'b0, operand} : '0);
            accOut = {1'b0, sum[XLEN:1]};
            mqOut  = {sum[0], mqIn[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/arith_seq_ctrl.sv
// arith_seq_ctrl: multi-cycle sequencer for MUL/MULH/MULHU/MULHSU/DIV/DIVU/REM/REMU.
//   clk    : clock
//   rst_n  : synchronous active-low reset
//   seqBus : arith_seq_ctrl_if.slave (request, flush and result handshakes)
// Operands are converted to magnitudes at accept, iterated one bit per cycle,
// and sign-corrected in FIXUP. Trivial cases finish on a fast path.
//
// state | meaning
// IDLE  | ready for a request
// RUN   | one shift-add / shift-subtract iteration per cycle
// FIXUP | sign correction, half/quotient/remainder select, flags
// DONE  | result held until consumed
module arith_seq_ctrl
    import ALUOperations::*;
#(
    parameter int XLEN       = 32,
    parameter bit EARLY_ZERO = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    arith_seq_ctrl_if.slave  seqBus
);

    localparam logic [XLEN-1:0]            MIN_INT    = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [ARITH_SEQ_CNT_W-1:0] LAST_COUNT = ARITH_SEQ_CNT_W'(ARITH_SEQ_ITERS - 1);

    seq_state_t state, stateNext;
    logic       inReady, outValid, accept;

    alu_op_t                      opReg;
    logic [ARITH_SEQ_CNT_W-1:0]   count;
    logic [XLEN:0]                accReg;
    logic [XLEN-1:0]              mqReg;
    logic [XLEN-1:0]              operandReg;
    logic                         negResult;
    logic                         negRem;
    logic [XLEN-1:0]              resultReg;
    logic [FLAG_W-1:0]            flagsReg;

    alu_op_t         opIn;
    logic [XLEN-1:0] aIn, bIn;
    logic            aNeg, bNeg;
    logic [XLEN-1:0] magA, magB;
    logic            divZero, divOvf, mulZero, unsupported, fastPath;
    logic [XLEN-1:0] fastResult;
    logic [FLAG_W-1:0] fastFlags;

    logic [XLEN:0]     stepAcc;
    logic [XLEN-1:0]   stepMq;
    logic [2*XLEN-1:0] product, signedProduct;
    logic [XLEN-1:0]   quotient, remainder, fixResult;

    assign opIn = seqBus.in_op;
    assign aIn  = seqBus.in_a;
    assign bIn  = seqBus.in_b;

    // Request decode: magnitudes and fast-path detection.
    always_comb begin
        aNeg        = opSignedA(opIn) & aIn[XLEN-1];
        bNeg        = opSignedB(opIn) & bIn[XLEN-1];
        magA        = aNeg ? -aIn : aIn;
        magB        = bNeg ? -bIn : bIn;
        divZero     = isDivOp(opIn) && (bIn == '0);
        divOvf      = (opIn inside {ALU_DIV, ALU_REM}) && (aIn == MIN_INT) && (bIn == '1);
        mulZero     = EARLY_ZERO && isMulOp(opIn) && ((aIn == '0) || (bIn == '0));
        unsupported = !isMulOp(opIn) && !isDivOp(opIn);
        fastPath    = divZero || divOvf || mulZero || unsupported;
        fastResult  = (divOvf && (opIn == ALU_DIV)) ? MIN_INT : '0;
        fastFlags   = makeFlags(fastResult, divZero, divOvf && (opIn == ALU_DIV));
    end

    arith_seq_step #(.XLEN(XLEN)) u_step (
        .accIn   (accReg),
        .mqIn    (mqReg),
        .operand (operandReg),
        .mode    (isDivOp(opReg) ? STEP_DIV : STEP_MUL),
        .accOut  (stepAcc),
        .mqOut   (stepMq)
    );

    always_comb begin
        product       = {accReg[XLEN-1:0], mqReg};
        signedProduct = negResult ? -product : product;
        quotient      = negResult ? -mqReg : mqReg;
        remainder     = negRem ? -accReg[XLEN-1:0] : accReg[XLEN-1:0];
        fixResult     = '0;
        case (opReg)
            ALU_MUL:                          fixResult = signedProduct[XLEN-1:0];
            ALU_MULH, ALU_MULHSU, ALU_MULHU:  fixResult = signedProduct[2*XLEN-1:XLEN];
            ALU_DIV, ALU_DIVU:                fixResult = quotient;
            ALU_REM, ALU_REMU:                fixResult = remainder;
            default:                          fixResult = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        inReady   = 1'b0;
        outValid  = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                inReady = 1'b1;
                if (seqBus.in_valid && !seqBus.flush) begin
                    accept    = 1'b1;
                    stateNext = fastPath ? DONE : RUN;
                end
            end
            RUN: begin
                if (count == LAST_COUNT) begin
                    stateNext = FIXUP;
                end
            end
            FIXUP: begin
                stateNext = DONE;
            end
            DONE: begin
                outValid = 1'b1;
                if (seqBus.out_ready) begin
                    stateNext = IDLE;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
        if (seqBus.flush) begin
            stateNext = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            opReg      <= ALU_ADD;
            count      <= '0;
            accReg     <= '0;
            mqReg      <= '0;
            operandReg <= '0;
            negResult  <= 1'b0;
            negRem     <= 1'b0;
            resultReg  <= '0;
            flagsReg   <= '0;
        end else if (seqBus.flush) begin
            resultReg  <= '0;
            flagsReg   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        opReg      <= opIn;
                        count      <= '0;
                        accReg     <= '0;
                        mqReg      <= magA;
                        operandReg <= magB;
                        negResult  <= aNeg ^ bNeg;
                        negRem     <= aNeg;
                        if (fastPath) begin
                            resultReg <= fastResult;
                            flagsReg  <= fastFlags;
                        end
                    end
                end
                RUN: begin
                    count  <= count + 1'b1;
                    accReg <= stepAcc;
                    mqReg  <= stepMq;
                end
                FIXUP: begin
                    resultReg <= fixResult;
                    flagsReg  <= makeFlags(fixResult, 1'b0, 1'b0);
                end
                default: begin
                end
            endcase
        end
    end

    assign seqBus.in_ready   = inReady;
    assign seqBus.out_valid  = outValid;
    assign seqBus.out_result = resultReg;
    assign seqBus.out_flags  = flagsReg;

endmodule

// File: tb/tb_arith_seq_ctrl.sv
module tb_arith_seq_ctrl;
    import ALUOperations::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    arith_seq_ctrl_if bus();

    arith_seq_ctrl #(.XLEN(32), .EARLY_ZERO(1'b1)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .seqBus (bus)
    );

    typedef struct {
        alu_op_t     op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        bit          dz;
        bit          ov;
        int          lat;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic [6:0]  flags;
        int          lat;
    } exp_t;

    vec_t vecs[$];
    exp_t sbq[$];
    int   nCmp = 0;
    int   nErr = 0;

    // Flag vector {div0, carry, ovf, evenParity, oddParity, sign, zero}.
    function automatic logic [6:0] expFlags(input logic [31:0] r, input bit dz, input bit ov);
        int pc;
        pc = $countones(r);
        return {dz, 1'b0, ov, (pc % 2 == 0), (pc % 2 == 1), r[31], (r == 32'd0)};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nCmp++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the first negedge after the accept edge.
    task automatic issue(input alu_op_t op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] res, input bit dz, input bit ov,
                         input int lat, input bit track);
        int t;
        t = 0;
        while (!bus.in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("issue in_ready", 64'(bus.in_ready), 64'd1);
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_a     = a;
        bus.in_b     = b;
        if (track) sbq.push_back('{res, expFlags(res, dz, ov), lat});
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_op    = ALU_MULHU;
        bus.in_a     = $urandom;
        bus.in_b     = $urandom;
        check("accepted in_ready low", 64'(bus.in_ready), 64'd0);
    endtask

    task automatic collect(input string name, input int hold);
        exp_t e;
        int   k;
        k = 1;
        while (!bus.out_valid && k < 60) begin
            @(negedge clk);
            k++;
        end
        if (sbq.size() == 0) begin
            nCmp++;
            nErr++;
            $display("FAIL %s scoreboard: got 0 entries expected 1", name);
            return;
        end
        e = sbq.pop_front();
        check({name, " out_valid"}, 64'(bus.out_valid), 64'd1);
        check({name, " latency"}, 64'(k), 64'(e.lat));
        check({name, " result"}, 64'(bus.out_result), 64'(e.res));
        check({name, " flags"}, 64'(bus.out_flags), 64'(e.flags));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({name, " hold valid"}, 64'(bus.out_valid), 64'd1);
            check({name, " hold result"}, 64'(bus.out_result), 64'(e.res));
            check({name, " hold flags"}, 64'(bus.out_flags), 64'(e.flags));
            check({name, " hold in_ready"}, 64'(bus.in_ready), 64'd0);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        check({name, " consumed"}, 64'(bus.out_valid), 64'd0);
        check({name, " ready again"}, 64'(bus.in_ready), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_op     = ALU_ADD;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;

        vecs.push_back('{ALU_MUL,    32'd7,          32'hFFFFFFFD, 32'hFFFFFFEB, 0, 0, 34});
        vecs.push_back('{ALU_MULH,   32'h80000000,   32'h80000000, 32'h40000000, 0, 0, 34});
        vecs.push_back('{ALU_MULHU,  32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFE, 0, 0, 34});
        vecs.push_back('{ALU_MULHSU, 32'hFFFFFFFF,   32'h00000002, 32'hFFFFFFFF, 0, 0, 34});
        vecs.push_back('{ALU_DIV,    32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD, 0, 0, 34});
        vecs.push_back('{ALU_REM,    32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF, 0, 0, 34});
        vecs.push_back('{ALU_DIVU,   32'd100,        32'd7,        32'd14,       0, 0, 34});
        vecs.push_back('{ALU_REMU,   32'd100,        32'd7,        32'd2,        0, 0, 34});
        vecs.push_back('{ALU_DIVU,   32'd5,          32'd0,        32'd0,        1, 0, 1});
        vecs.push_back('{ALU_REM,    32'd9,          32'd0,        32'd0,        1, 0, 1});
        vecs.push_back('{ALU_DIV,    32'h80000000,   32'hFFFFFFFF, 32'h80000000, 0, 1, 1});
        vecs.push_back('{ALU_REM,    32'h80000000,   32'hFFFFFFFF, 32'd0,        0, 0, 1});
        vecs.push_back('{ALU_MUL,    32'd0,          32'h1234,     32'd0,        0, 0, 1});
        vecs.push_back('{ALU_MULHU,  32'd5,          32'd0,        32'd0,        0, 0, 1});
        vecs.push_back('{ALU_ADD,    32'd3,          32'd4,        32'd0,        0, 0, 1});
        vecs.push_back('{ALU_DIV,    32'h80000000,   32'd3,        32'hD5555556, 0, 0, 34});
        vecs.push_back('{ALU_REM,    32'h80000000,   32'd3,        32'hFFFFFFFE, 0, 0, 34});
        vecs.push_back('{ALU_MUL,    32'hFFFFFFFF,   32'hFFFFFFFF, 32'd1,        0, 0, 34});
        vecs.push_back('{ALU_DIVU,   32'hFFFFFFFF,   32'h10,       32'h0FFFFFFF, 0, 0, 34});
        vecs.push_back('{ALU_REMU,   32'hFFFFFFFF,   32'h10,       32'hF,        0, 0, 34});
        vecs.push_back('{ALU_MULHU,  32'h80000000,   32'd2,        32'd1,        0, 0, 34});
        vecs.push_back('{ALU_DIV,    32'd7,          32'hFFFFFFFE, 32'hFFFFFFFD, 0, 0, 34});
        vecs.push_back('{ALU_REM,    32'd7,          32'hFFFFFFFE, 32'd1,        0, 0, 34});
        vecs.push_back('{ALU_DIVU,   32'd3,          32'd7,        32'd0,        0, 0, 34});

        repeat (3) @(negedge clk);
        check("reset out_valid", 64'(bus.out_valid), 64'd0);
        check("reset in_ready", 64'(bus.in_ready), 64'd1);
        check("reset result", 64'(bus.out_result), 64'd0);
        check("reset flags", 64'(bus.out_flags), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].dz, vecs[i].ov,
                  vecs[i].lat, 1'b1);
            collect($sformatf("vec%0d", i), 0);
        end

        // Stall in DONE, then back-to-back accept right after the handshake.
        bus.out_ready = 1'b0;
        issue(ALU_DIVU, 32'd100, 32'd7, 32'd14, 0, 0, 34, 1'b1);
        collect("hold", 5);
        issue(ALU_REMU, 32'd100, 32'd7, 32'd2, 0, 0, 34, 1'b1);
        collect("backToBack", 0);

        // Reset in the middle of RUN.
        issue(ALU_MUL, 32'd7, 32'd3, 32'd0, 0, 0, 0, 1'b0);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midReset out_valid", 64'(bus.out_valid), 64'd0);
        check("midReset in_ready", 64'(bus.in_ready), 64'd1);
        check("midReset result", 64'(bus.out_result), 64'd0);
        check("midReset flags", 64'(bus.out_flags), 64'd0);
        rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        check("midReset no result", 64'(seen), 64'd0);
        issue(ALU_DIVU, 32'd100, 32'd7, 32'd14, 0, 0, 34, 1'b1);
        collect("afterReset", 0);

        // Flush 10 cycles into a divide.
        issue(ALU_DIV, 32'hFFFFFFF9, 32'd2, 32'd0, 0, 0, 0, 1'b0);
        repeat (9) @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        check("flushRun out_valid", 64'(bus.out_valid), 64'd0);
        check("flushRun in_ready", 64'(bus.in_ready), 64'd1);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        check("flushRun no result", 64'(seen), 64'd0);

        // Flush beats a simultaneous request in IDLE.
        bus.in_valid = 1'b1;
        bus.in_op    = ALU_DIVU;
        bus.in_a     = 32'd5;
        bus.in_b     = 32'd0;
        bus.flush    = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
        check("flushIdle out_valid", 64'(bus.out_valid), 64'd0);
        check("flushIdle in_ready", 64'(bus.in_ready), 64'd1);

        // Flush together with out_ready in DONE delivers nothing.
        bus.out_ready = 1'b0;
        issue(ALU_DIV, 32'h80000000, 32'hFFFFFFFF, 32'd0, 0, 0, 0, 1'b0);
        check("flushDone out_valid", 64'(bus.out_valid), 64'd1);
        check("flushDone result", 64'(bus.out_result), 64'h80000000);
        bus.flush     = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        check("flushDone dropped", 64'(bus.out_valid), 64'd0);
        check("flushDone in_ready", 64'(bus.in_ready), 64'd1);

        check("scoreboard drained", 64'(sbq.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule
